// File: rtl/alu_sequencer.sv
// Issue sequencer for the 8-bit combinational ALU: accepts instructions, reads the 4x8 register file,
// drives the ALU, writes back and returns results. Optional macro ALU_SEQ_ZERO_FLAG_EN adds res_zero.
module alu_sequencer #(
  parameter logic [7:0] RESET_REG_VAL   = 8'h00,
  parameter bit         ERR_ON_RESERVED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_sel,
  input  logic [7:0]  alu_out,
  input  logic        alu_carry,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic        res_carry,
  output logic        res_err,
`ifdef ALU_SEQ_ZERO_FLAG_EN
  output logic        res_zero,
`endif
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high; valid never
  // depends on ready, and the offering side holds its payload stable until that edge.

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_LDI = 4'b1110;
  localparam logic [3:0] OP_RSV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  regs [4];
  logic [3:0]  op_q;
  logic [1:0]  rd_q;
  logic [7:0]  imm_q;
  logic        carry_flag;

  logic        accept;
  logic [3:0]  instr_op;
  logic [7:0]  result;
  logic        do_write;
  logic        err_next;
  logic        carry_next;

  assign instr_op  = instr[15:12];
  assign accept    = instr_valid && instr_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) next_state = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Result selection while the ALU inputs are stable in EXEC.
  always_comb begin
    result   = (op_q == OP_LDI) ? imm_q : alu_out;
    do_write = 1'b0;
    err_next = 1'b0;
    if (op_q == OP_RSV)                          err_next = ERR_ON_RESERVED;
    else if (op_q == OP_DIV && alu_b == 8'h00)   err_next = 1'b1;
    else                                         do_write = 1'b1;
    carry_next = (op_q == OP_ADD) ? alu_carry : carry_flag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= RESET_REG_VAL;
      op_q       <= 4'h0;
      rd_q       <= 2'd0;
      imm_q      <= 8'h00;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_sel    <= 4'h0;
      carry_flag <= 1'b0;
      res_valid  <= 1'b0;
      res_data   <= 8'h00;
      res_carry  <= 1'b0;
      res_err    <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      res_zero   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        op_q    <= instr_op;
        rd_q    <= instr[11:10];
        imm_q   <= instr[7:0];
        alu_a   <= regs[instr[9:8]];
        alu_b   <= regs[instr[7:6]];
        // LDI and the reserved opcode do not use the ALU, so present a harmless ADD.
        alu_sel <= (instr_op[3:1] == 3'b111) ? 4'h0 : instr_op;
      end

      if (state == EXEC) begin
        if (do_write) begin
          regs[rd_q] <= result;
          res_data   <= result;
        end else begin
          res_data   <= 8'h00;
        end
        res_err    <= err_next;
        carry_flag <= carry_next;
        res_carry  <= carry_next;
        res_valid  <= 1'b1;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        res_zero   <= do_write && (result == 8'h00);
`endif
      end

      if (state == RESP && res_ready) res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU + register-file model, directed and random tests.
module tb_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_carry;
  logic        res_err;
  logic [1:0]  dbg_state;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic        res_zero;
  logic        n_res_zero;
`endif

  // Second instance with the reserved opcode treated as a silent NOP.
  logic        n_instr_valid;
  logic        n_instr_ready;
  logic [15:0] n_instr;
  logic [7:0]  n_alu_a;
  logic [7:0]  n_alu_b;
  logic [3:0]  n_alu_sel;
  logic [7:0]  n_alu_out;
  logic        n_alu_carry;
  logic        n_res_valid;
  logic        n_res_ready;
  logic [7:0]  n_res_data;
  logic        n_res_carry;
  logic        n_res_err;
  logic [1:0]  n_dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;
  int accept_cnt = 0;

  logic [7:0] ref_regs [4];
  logic       ref_carry;
  logic       obs_zero;

  alu_sequencer #(.RESET_REG_VAL(8'h00), .ERR_ON_RESERVED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_carry(res_carry),
    .res_err(res_err),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .res_zero(res_zero),
`endif
    .dbg_state(dbg_state)
  );

  alu_sequencer #(.RESET_REG_VAL(8'h00), .ERR_ON_RESERVED(1'b0)) u_dut_nop (
    .clk(clk), .rst_n(rst_n), .instr_valid(n_instr_valid), .instr_ready(n_instr_ready), .instr(n_instr),
    .alu_a(n_alu_a), .alu_b(n_alu_b), .alu_sel(n_alu_sel), .alu_out(n_alu_out), .alu_carry(n_alu_carry),
    .res_valid(n_res_valid), .res_ready(n_res_ready), .res_data(n_res_data), .res_carry(n_res_carry),
    .res_err(n_res_err),
`ifdef ALU_SEQ_ZERO_FLAG_EN
    .res_zero(n_res_zero),
`endif
    .dbg_state(n_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) if (instr_valid && instr_ready) accept_cnt++;

  // ---------------- behavioural ALU ----------------
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    case (s)
      4'd0:  return {1'b0, a} + {1'b0, b};
      4'd1:  return {1'b0, a - b};
      4'd2:  return {1'b0, a * b};
      4'd3:  return (b == 8'h00) ? 9'd0 : {1'b0, a / b};
      4'd4:  return {1'b0, a << 1};
      4'd5:  return {1'b0, a >> 1};
      4'd6:  return {1'b0, a[6:0], a[7]};
      4'd7:  return {1'b0, a[0], a[7:1]};
      4'd8:  return {1'b0, a & b};
      4'd9:  return {1'b0, a | b};
      4'd10: return {1'b0, a ^ b};
      4'd11: return {1'b0, ~(a | b)};
      4'd12: return {1'b0, ~(a & b)};
      4'd13: return {1'b0, ~(a ^ b)};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] alu9;
  always_comb alu9 = alu_ref(alu_a, alu_b, alu_sel);
  assign alu_out   = alu9[7:0];
  assign alu_carry = alu9[8];
  assign n_alu_out   = 8'h00;
  assign n_alu_carry = 1'b0;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
    ref_carry = 1'b0;
  endtask

  // Architectural effect of one instruction on the main DUT (reserved opcode is an error there).
  task automatic model(input logic [15:0] ins, output logic [7:0] d, output logic c, output logic e);
    logic [3:0] op;
    logic [8:0] r;
    op = ins[15:12];
    d = 8'h00;
    e = 1'b0;
    if (op == 4'hF) e = 1'b1;
    else if (op == 4'h3 && ref_regs[ins[7:6]] == 8'h00) e = 1'b1;
    else begin
      r = alu_ref(ref_regs[ins[9:8]], ref_regs[ins[7:6]], op);
      d = (op == 4'hE) ? ins[7:0] : r[7:0];
      if (op == 4'h0) ref_carry = r[8];
      ref_regs[ins[11:10]] = d;
    end
    c = ref_carry;
  endtask

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] ra,
                                      input logic [1:0] rb);
    return {op, rd, ra, rb, 6'b000000};
  endfunction

  function automatic logic [15:0] enc_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'hE, rd, 2'b00, imm};
  endfunction

  // ---------------- driver ----------------
  task automatic send(input logic [15:0] ins, output logic [7:0] d, output logic c, output logic e,
                      output int lat, output logic [3:0] sel, output bit to);
    int n;
    to = 1'b0; lat = 0; sel = 4'h0; d = 8'h00; c = 1'b0; e = 1'b0; n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    if (!instr_ready) begin to = 1'b1; return; end
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    sel = alu_sel;
    lat = 1;
    while (!res_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!res_valid) begin to = 1'b1; return; end
    d = res_data; c = res_carry; e = res_err;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    obs_zero = res_zero;
`endif
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vec_cnt++;
    if (instr_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_instr_ready: got %b want 1", instr_ready); end
    vec_cnt++;
    if (res_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    vec_cnt++;
    if ({res_data, res_carry, res_err} !== 10'h000) begin
      err_cnt++; $display("FAIL reset_res: got %h/%b/%b want 00/0/0", res_data, res_carry, res_err);
    end
    vec_cnt++;
    if ({alu_a, alu_b, alu_sel} !== 20'h00000) begin
      err_cnt++; $display("FAIL reset_alu: got %h/%h/%h want 00/00/0", alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_plan();
    logic [15:0] prog [6];
    logic [7:0] d, ed;
    logic c, e, ec, ee;
    logic [3:0] sel;
    int lat;
    bit to;
    prog[0] = enc_ldi(2'd1, 8'hF0);
    prog[1] = enc_ldi(2'd2, 8'h20);
    prog[2] = enc(4'h0, 2'd3, 2'd1, 2'd2);
    prog[3] = enc(4'h3, 2'd0, 2'd1, 2'd0);
    prog[4] = enc(4'h9, 2'd0, 2'd0, 2'd0);
    prog[5] = enc(4'h1, 2'd0, 2'd2, 2'd1);
    for (int i = 0; i < 6; i++) begin
      send(prog[i], d, c, e, lat, sel, to);
      model(prog[i], ed, ec, ee);
      vec_cnt++;
      if (to || {d, c, e} !== {ed, ec, ee}) begin
        err_cnt++;
        $display("FAIL plan_step%0d: got d=%h c=%b e=%b to=%0d want d=%h c=%b e=%b", i, d, c, e, to, ed, ec, ee);
      end
      if (i == 2) begin
        vec_cnt++;
        if ({d, c, sel} !== {8'h10, 1'b1, 4'h0} || lat != 2) begin
          err_cnt++; $display("FAIL plan_add: got d=%h c=%b sel=%h lat=%0d want 10/1/0/2", d, c, sel, lat);
        end
      end
      if (i == 3) begin
        vec_cnt++;
        if ({d, e} !== {8'h00, 1'b1}) begin
          err_cnt++; $display("FAIL plan_div0: got d=%h e=%b want 00/1", d, e);
        end
      end
      if (i == 5) begin
        vec_cnt++;
        if ({d, c, sel} !== {8'h30, 1'b1, 4'h1}) begin
          err_cnt++; $display("FAIL plan_sub: got d=%h c=%b sel=%h want 30/1/1", d, c, sel);
        end
      end
    end
  endtask

  task automatic test_reserved();
    logic [7:0] d, ed;
    logic c, e, ec, ee;
    logic [3:0] sel;
    logic [15:0] ins;
    int lat;
    bit to;
    ins = {4'hF, 2'd1, 2'd2, 8'hC3};
    send(ins, d, c, e, lat, sel, to);
    model(ins, ed, ec, ee);
    vec_cnt++;
    if (to || {d, c, e} !== {8'h00, ec, 1'b1}) begin
      err_cnt++; $display("FAIL reserved_err: got d=%h c=%b e=%b want 00/%b/1", d, c, e, ec);
    end
    for (int r = 0; r < 4; r++) begin
      ins = enc(4'h9, r[1:0], r[1:0], r[1:0]);
      send(ins, d, c, e, lat, sel, to);
      model(ins, ed, ec, ee);
      vec_cnt++;
      if (to || {d, e} !== {ed, 1'b0}) begin
        err_cnt++; $display("FAIL reserved_readback_r%0d: got %h want %h", r, d, ed);
      end
    end
    // NOP flavour on the second instance.
    @(negedge clk);
    n_instr = 16'hF5A5;
    n_instr_valid = 1'b1;
    @(negedge clk);
    n_instr_valid = 1'b0;
    @(negedge clk);
    vec_cnt++;
    if ({n_res_valid, n_res_err, n_res_data} !== {1'b1, 1'b0, 8'h00}) begin
      err_cnt++;
      $display("FAIL reserved_nop: got v=%b e=%b d=%h want 1/0/00", n_res_valid, n_res_err, n_res_data);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [7:0] ed;
    logic ec, ee;
    logic [15:0] ins;
    int base, n;
    ins = enc(4'h0, 2'd2, 2'd1, 2'd3);
    @(negedge clk);
    base = accept_cnt;
    instr = ins;
    instr_valid = 1'b1;
    res_ready = 1'b0;
    model(ins, ed, ec, ee);
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      vec_cnt++;
      if ({res_valid, instr_ready, res_data, res_carry, res_err} !== {1'b1, 1'b0, ed, ec, ee}) begin
        err_cnt++;
        $display("FAIL bp_hold_%0d: got v=%b rdy=%b d=%h c=%b e=%b want 1/0/%h/%b/%b",
                 k, res_valid, instr_ready, res_data, res_carry, res_err, ed, ec, ee);
      end
      @(negedge clk);
    end
    vec_cnt++;
    if (accept_cnt - base != 1) begin
      err_cnt++; $display("FAIL bp_single_issue: got %0d accepts want 1", accept_cnt - base);
    end
    ins = enc_ldi(2'd0, 8'h5A);
    instr = ins;
    res_ready = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if ({instr_ready, res_valid} !== 2'b10) begin
      err_cnt++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", instr_ready, res_valid);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    model(ins, ed, ec, ee);
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    vec_cnt++;
    if ({res_valid, res_data, res_err} !== {1'b1, ed, 1'b0} || accept_cnt - base != 2) begin
      err_cnt++;
      $display("FAIL bp_next: got v=%b d=%h accepts=%0d want 1/%h/2", res_valid, res_data, accept_cnt - base, ed);
    end
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0] d, ed;
    logic c, e, ec, ee;
    logic [3:0] sel;
    logic [15:0] ins;
    int lat;
    bit to;
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hE;
      send(ins, d, c, e, lat, sel, to);
      model(ins, ed, ec, ee);
      vec_cnt++;
      if (to || lat != 2 || {d, c, e} !== {ed, ec, ee}) begin
        err_cnt++;
        $display("FAIL random_%0d ins=%h: got d=%h c=%b e=%b lat=%0d want d=%h c=%b e=%b lat=2",
                 i, ins, d, c, e, lat, ed, ec, ee);
      end
`ifdef ALU_SEQ_ZERO_FLAG_EN
      vec_cnt++;
      if (obs_zero !== (!ee && ed == 8'h00)) begin
        err_cnt++; $display("FAIL random_zero_%0d: got %b want %b", i, obs_zero, (!ee && ed == 8'h00));
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, ed;
    logic c, e, ec, ee;
    logic [3:0] sel;
    int lat, n;
    bit to;
    send(enc_ldi(2'd3, 8'h77), d, c, e, lat, sel, to);
    model(enc_ldi(2'd3, 8'h77), ed, ec, ee);
    @(negedge clk);
    n = 0;
    while (!instr_ready && n < 20) begin @(negedge clk); n++; end
    instr = enc(4'h0, 2'd3, 2'd1, 2'd2);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vec_cnt++;
      if (res_valid !== 1'b0) begin err_cnt++; $display("FAIL midreset_no_result_%0d: got v=%b want 0", k, res_valid); end
    end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    vec_cnt++;
    if ({instr_ready, res_valid} !== 2'b10) begin
      err_cnt++; $display("FAIL midreset_release: got rdy=%b v=%b want 1/0", instr_ready, res_valid);
    end
    send(enc(4'h9, 2'd3, 2'd3, 2'd3), d, c, e, lat, sel, to);
    model(enc(4'h9, 2'd3, 2'd3, 2'd3), ed, ec, ee);
    vec_cnt++;
    if (to || {d, c, e} !== {ed, ec, ee}) begin
      err_cnt++; $display("FAIL midreset_r3: got d=%h c=%b e=%b want d=%h c=%b e=%b", d, c, e, ed, ec, ee);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0000;
    res_ready = 1'b0;
    n_instr_valid = 1'b0;
    n_instr = 16'h0000;
    n_res_ready = 1'b1;
    obs_zero = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_plan();
    test_reserved();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
